// File: rtl/eng_ucq_port.sv
// Engine-side endpoint of the unit-clause arbiter link: sorted de-duplicated
// implied-literal queue (UCQ_IN), broadcast FIFO (UCQ_OUT) and stall status FSM.
module eng_ucq_port #(
  parameter int unsigned LIT_W     = 16,
  parameter int unsigned IN_DEPTH  = 8,
  parameter int unsigned OUT_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LIT_W-1:0] eng_imp_lit,
  input  logic             eng_imp_valid,
  output logic             eng_imp_ready,
  input  logic             eng_idle,
  output logic [LIT_W-1:0] eng2uca_min,
  output logic             eng2uca_valid,
  output logic             eng2uca_empty,
  input  logic             uca2eng_pop,
  input  logic [LIT_W-1:0] uca2eng_lit,
  input  logic             uca2eng_push,
  output logic             eng2uca_full,
  output logic             eng2uca_stall,
  output logic [LIT_W-1:0] eng_bc_lit,
  output logic             eng_bc_valid,
  input  logic             eng_bc_ready,
  input  logic             uca_flush
);

  localparam int unsigned IN_CW  = $clog2(IN_DEPTH + 1);
  localparam int unsigned OUT_AW = $clog2(OUT_DEPTH);
  localparam int unsigned OUT_CW = OUT_AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_DRAIN
  } state_t;

  // UCQ_IN storage: slots at or above r_in_count are always held at zero
  logic [LIT_W-1:0]    r_in_q [IN_DEPTH];
  logic [IN_CW-1:0]    r_in_count;

  logic [LIT_W-1:0]    w_in_after [IN_DEPTH];
  logic [LIT_W-1:0]    w_in_next  [IN_DEPTH];
  logic [IN_DEPTH-1:0] w_in_lt;
  logic                w_in_pop;
  logic                w_in_dup;
  logic                w_in_push;
  logic [IN_CW-1:0]    w_in_cnt_after;
  logic [IN_CW-1:0]    w_in_cnt_next;

  logic [LIT_W-1:0]    r_out_mem [OUT_DEPTH];
  logic [OUT_AW-1:0]   r_wp;
  logic [OUT_AW-1:0]   r_rp;
  logic [OUT_CW-1:0]   r_out_count;
  logic                w_out_full;
  logic                w_out_rd;
  logic                w_out_wr;

  state_t              r_state;
  logic                w_any_push;
  logic                w_both_empty;

  assign eng_imp_ready = (r_in_count != IN_CW'(IN_DEPTH));
  assign eng2uca_valid = (r_in_count != '0);
  assign eng2uca_empty = (r_in_count == '0);
  assign eng2uca_min   = r_in_q[0];

  assign w_out_full    = (r_out_count == OUT_CW'(OUT_DEPTH));
  assign eng2uca_full  = w_out_full;
  assign eng_bc_valid  = (r_out_count != '0);
  assign eng_bc_lit    = (r_out_count != '0) ? r_out_mem[r_rp] : '0;
  assign w_out_rd      = (r_out_count != '0) && eng_bc_ready;
  assign w_out_wr      = uca2eng_push && (!w_out_full || w_out_rd);

  assign w_any_push    = w_in_push || w_out_wr;
  assign w_both_empty  = (r_in_count == '0) && (r_out_count == '0);
  assign eng2uca_stall = (r_state == S_IDLE) && eng_idle;

  // Pop is applied first (shift down), then the new literal is inserted at the
  // first slot whose post-pop value is not below it; larger entries shift up.
  always_comb begin
    w_in_pop = uca2eng_pop && (r_in_count != '0);
    w_in_dup = 1'b0;
    for (int unsigned i = 0; i < IN_DEPTH; i++) begin
      if ((IN_CW'(i) < r_in_count) && (r_in_q[i] == eng_imp_lit)) begin
        w_in_dup = 1'b1;
      end
    end
    w_in_push = eng_imp_valid && eng_imp_ready && (eng_imp_lit != '0) && !w_in_dup;

    for (int unsigned i = 0; i < IN_DEPTH - 1; i++) begin
      w_in_after[i] = w_in_pop ? r_in_q[i+1] : r_in_q[i];
    end
    w_in_after[IN_DEPTH-1] = w_in_pop ? '0 : r_in_q[IN_DEPTH-1];
    w_in_cnt_after = r_in_count - IN_CW'(w_in_pop);

    for (int unsigned i = 0; i < IN_DEPTH; i++) begin
      w_in_lt[i] = (IN_CW'(i) < w_in_cnt_after) && (w_in_after[i] < eng_imp_lit);
    end

    w_in_next[0] = (!w_in_push || w_in_lt[0]) ? w_in_after[0] : eng_imp_lit;
    for (int unsigned i = 1; i < IN_DEPTH; i++) begin
      if (!w_in_push || w_in_lt[i]) begin
        w_in_next[i] = w_in_after[i];
      end else if (w_in_lt[i-1]) begin
        w_in_next[i] = eng_imp_lit;
      end else begin
        w_in_next[i] = w_in_after[i-1];
      end
    end
    w_in_cnt_next = w_in_cnt_after + IN_CW'(w_in_push);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < IN_DEPTH; i++) begin
        r_in_q[i] <= '0;
      end
      r_in_count <= '0;
    end else if (uca_flush) begin
      for (int unsigned i = 0; i < IN_DEPTH; i++) begin
        r_in_q[i] <= '0;
      end
      r_in_count <= '0;
    end else begin
      for (int unsigned i = 0; i < IN_DEPTH; i++) begin
        r_in_q[i] <= w_in_next[i];
      end
      r_in_count <= w_in_cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_out_wr && !uca_flush) begin
      r_out_mem[r_wp] <= uca2eng_lit;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp        <= '0;
      r_rp        <= '0;
      r_out_count <= '0;
    end else if (uca_flush) begin
      r_wp        <= '0;
      r_rp        <= '0;
      r_out_count <= '0;
    end else begin
      if (w_out_wr) begin
        r_wp <= r_wp + 1'b1;
      end
      if (w_out_rd) begin
        r_rp <= r_rp + 1'b1;
      end
      case ({w_out_wr, w_out_rd})
        2'b10:   r_out_count <= r_out_count + 1'b1;
        2'b01:   r_out_count <= r_out_count - 1'b1;
        default: r_out_count <= r_out_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else if (uca_flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_push) begin
            r_state <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (eng_idle) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!eng_idle || w_any_push) begin
            r_state <= S_ACTIVE;
          end else if (w_both_empty) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
